// File: rtl/scan_readout_rx.sv
// scan_readout_rx
// Scan-chain readout controller and deserializer for the FIR tap arrays.
// It drives scan enable and freeze into the FIR and samples the two bit-serial
// streams, weight and sample. It rebuilds one 26-bit weight and one 16-bit
// sample per tap, and presents them in tap order TAPS-1 down to 0.
//
// Ports:
//   clk, rst_n          clock shared with the FIR scan logic; async active-low reset
//   i_start             readout request pulse, honoured only when idle
//   i_scan_out_w/_x     weight / sample scan bits from the FIR, LSB first
//   o_scan_en           scan enable to the FIR (registered)
//   o_scan_freeze       freeze to the FIR (registered; never driven when FREEZE=0)
//   o_busy              readout in progress (low again in the done cycle)
//   o_word_valid        one-cycle pulse qualifying o_tap_idx/o_w_word/o_x_word
//   o_tap_idx           tap index of the current word
//   o_w_word            signed weight as stored in the FIR
//   o_x_word            signed sample
//   o_x_fmt_err         sticky: a sample word had nonzero padding bits 16..25
//   o_done              one-cycle pulse together with the last word
//
// State table:
//   IDLE  | waiting for i_start
//   ARM   | one lead cycle with the FIR frozen before shifting (FREEZE=1 only)
//   SHIFT | 26*TAPS scan cycles, one bit per stream per cycle
module scan_readout_rx #(
  parameter int TAPS   = 256,
  parameter int M      = 8,
  parameter bit FREEZE = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_scan_out_w,
  input  logic          i_scan_out_x,
  output logic          o_scan_en,
  output logic          o_scan_freeze,
  output logic          o_busy,
  output logic          o_word_valid,
  output logic [M-1:0]  o_tap_idx,
  output logic [25:0]   o_w_word,
  output logic [15:0]   o_x_word,
  output logic          o_x_fmt_err,
  output logic          o_done
);

  typedef enum logic [1:0] {IDLE, ARM, SHIFT} state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [4:0]   r_bit_cnt;
  logic [M-1:0] r_word_cnt;
  // Only the upper 25 bits of the 26-bit shift window are kept: the oldest
  // bit falls out on the same edge the new bit arrives, so it is never read.
  logic [24:0]  r_sh_w;
  logic [24:0]  r_sh_x;

  logic         r_scan_en;
  logic         r_scan_freeze;
  logic         r_busy;
  logic         r_word_valid;
  logic [M-1:0] r_tap_idx;
  logic [25:0]  r_w_word;
  logic [15:0]  r_x_word;
  logic         r_x_fmt_err;
  logic         r_done;

  logic         w_accept;
  logic         w_bit_last;
  logic         w_word_last;
  logic         w_enter_shift;
  logic [25:0]  w_sh_w_nxt;
  logic [25:0]  w_sh_x_nxt;

  assign w_accept      = (r_state == IDLE) && i_start;
  assign w_bit_last    = (r_bit_cnt == 5'd25);
  assign w_word_last   = (r_word_cnt == M'(TAPS - 1));
  assign w_enter_shift = (w_state_nxt == SHIFT) && (r_state != SHIFT);
  assign w_sh_w_nxt    = {i_scan_out_w, r_sh_w};
  assign w_sh_x_nxt    = {i_scan_out_x, r_sh_x};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = FREEZE ? ARM : SHIFT;
      ARM:     w_state_nxt = SHIFT;
      SHIFT:   if (w_bit_last && w_word_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with
  // the state register without a decode stage on the FIR-facing pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_en     <= 1'b0;
      r_scan_freeze <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_scan_en     <= (w_state_nxt == SHIFT);
      r_scan_freeze <= FREEZE & (w_state_nxt != IDLE);
      r_busy        <= (w_state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
      r_sh_w       <= '0;
      r_sh_x       <= '0;
      r_word_valid <= 1'b0;
      r_done       <= 1'b0;
      r_tap_idx    <= '0;
      r_w_word     <= '0;
      r_x_word     <= '0;
      r_x_fmt_err  <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      r_done       <= 1'b0;
      if (w_accept) r_x_fmt_err <= 1'b0;
      if (w_enter_shift) begin
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
      end else if (r_state == SHIFT) begin
        r_sh_w <= w_sh_w_nxt[25:1];
        r_sh_x <= w_sh_x_nxt[25:1];
        if (w_bit_last) begin
          r_w_word     <= w_sh_w_nxt;
          r_x_word     <= w_sh_x_nxt[15:0];
          // Padding bits are zeros, not sign extension; anything else means
          // the chain and this counter have slipped.
          if (|w_sh_x_nxt[25:16]) r_x_fmt_err <= 1'b1;
          r_tap_idx    <= M'(TAPS - 1) - r_word_cnt;
          r_word_valid <= 1'b1;
          r_done       <= w_word_last;
          r_bit_cnt    <= '0;
          r_word_cnt   <= r_word_cnt + 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
      end
    end
  end

  assign o_scan_en     = r_scan_en;
  assign o_scan_freeze = r_scan_freeze;
  assign o_busy        = r_busy;
  assign o_word_valid  = r_word_valid;
  assign o_tap_idx     = r_tap_idx;
  assign o_w_word      = r_w_word;
  assign o_x_word      = r_x_word;
  assign o_x_fmt_err   = r_x_fmt_err;
  assign o_done        = r_done;

endmodule

// File: tb/tb_scan_readout_rx.sv
// Testbench for scan_readout_rx: two instances with TAPS=4 (FREEZE=1 and
// FREEZE=0), each fed by a behavioural FIR scan-chain model.
module tb_scan_readout_rx;
  localparam int TAPS = 4;
  localparam int NB   = 26 * TAPS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r_start = 1'b0;
  logic sel = 1'b0;
  logic inj = 1'b0;

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [25:0] w_mem [TAPS];
  logic [15:0] x_mem [TAPS];

  logic en_f, fz_f, busy_f, vld_f, err_f, done_f, sw_f, sx_f;
  logic en_n, fz_n, busy_n, vld_n, err_n, done_n, sw_n, sx_n;
  logic [1:0]  tap_f, tap_n;
  logic [25:0] w_f, w_n;
  logic [15:0] x_f, x_n;

  scan_readout_rx #(.TAPS(TAPS), .M(2), .FREEZE(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n), .i_start(r_start & ~sel),
    .i_scan_out_w(sw_f), .i_scan_out_x(sx_f),
    .o_scan_en(en_f), .o_scan_freeze(fz_f), .o_busy(busy_f),
    .o_word_valid(vld_f), .o_tap_idx(tap_f), .o_w_word(w_f), .o_x_word(x_f),
    .o_x_fmt_err(err_f), .o_done(done_f));

  scan_readout_rx #(.TAPS(TAPS), .M(2), .FREEZE(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .i_start(r_start & sel),
    .i_scan_out_w(sw_n), .i_scan_out_x(sx_n),
    .o_scan_en(en_n), .o_scan_freeze(fz_n), .o_busy(busy_n),
    .o_word_valid(vld_n), .o_tap_idx(tap_n), .o_w_word(w_n), .o_x_word(x_n),
    .o_x_fmt_err(err_n), .o_done(done_n));

  // FIR scan-chain model: position advances on every edge with scan enable;
  // position c carries bit c%26 of word c/26, i.e. tap TAPS-1-c/26.
  int cnt_f, cnt_n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_f <= 0;
      cnt_n <= 0;
    end else begin
      if (en_f) cnt_f <= (cnt_f == NB - 1) ? 0 : cnt_f + 1;
      if (en_n) cnt_n <= (cnt_n == NB - 1) ? 0 : cnt_n + 1;
    end
  end

  function automatic logic wbit(input int c);
    logic [25:0] v;
    v = w_mem[TAPS - 1 - c / 26];
    return v[c % 26];
  endfunction

  function automatic logic xbit(input int c, input logic inject);
    logic [25:0] v;
    v = {10'd0, x_mem[TAPS - 1 - c / 26]};
    if (inject && (c / 26 == 1) && (c % 26 == 20)) return 1'b1;
    return v[c % 26];
  endfunction

  always_comb begin
    sw_f = wbit(cnt_f);
    sx_f = xbit(cnt_f, inj);
    sw_n = wbit(cnt_n);
    sx_n = xbit(cnt_n, inj);
  end

  logic m_en, m_fz, m_busy, m_vld, m_err, m_done;
  logic [1:0]  m_tap;
  logic [25:0] m_w;
  logic [15:0] m_x;
  assign m_en   = sel ? en_n   : en_f;
  assign m_fz   = sel ? fz_n   : fz_f;
  assign m_busy = sel ? busy_n : busy_f;
  assign m_vld  = sel ? vld_n  : vld_f;
  assign m_err  = sel ? err_n  : err_f;
  assign m_done = sel ? done_n : done_f;
  assign m_tap  = sel ? tap_n  : tap_f;
  assign m_w    = sel ? w_n    : w_f;
  assign m_x    = sel ? x_n    : x_f;

  logic [1:0]  q_tap [$];
  logic [25:0] q_w   [$];
  logic [15:0] q_x   [$];
  logic        q_err [$];

  always @(negedge clk) begin
    if (m_vld) begin
      q_tap.push_back(m_tap);
      q_w.push_back(m_w);
      q_x.push_back(m_x);
      q_err.push_back(m_err);
    end
  end

  logic en_at_s, fz_at_s, err_at_s, fz_seen;

  task automatic clear_q();
    q_tap.delete(); q_w.delete(); q_x.delete(); q_err.delete();
  endtask

  // Runs one readout; counts falling edges after the start edge S.
  task automatic run(input bit do_start, input int restart_at, input bit b2b,
                     output int done_at, output int first_at, output int ndone);
    clear_q();
    fz_seen = 1'b0;
    if (do_start) begin
      @(negedge clk);
      r_start = 1'b1;
      @(posedge clk);
      #1;
      r_start  = 1'b0;
      en_at_s  = m_en;
      fz_at_s  = m_fz;
      err_at_s = m_err;
    end
    done_at = -1;
    first_at = -1;
    ndone = 0;
    for (int c = 1; c <= 2 * NB; c++) begin
      @(negedge clk);
      r_start = (c == restart_at) || (b2b && m_done);
      if (m_vld && first_at < 0) first_at = c;
      if (m_fz) fz_seen = 1'b1;
      if (m_done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (done_at > 0 && c == done_at + 1) begin
        if (!b2b) chk("scan_en_after_done", m_en, 1'b0);
        break;
      end
    end
    r_start = 1'b0;
    if (done_at < 0) chk("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic chk_words(input string tag);
    chk({tag, "_nwords"}, q_tap.size(), TAPS);
    for (int i = 0; i < TAPS && i < q_tap.size(); i++) begin
      chk({tag, "_tap"}, q_tap[i], TAPS - 1 - i);
      chk({tag, "_w"},   q_w[i],   w_mem[TAPS - 1 - i]);
      chk({tag, "_x"},   q_x[i],   x_mem[TAPS - 1 - i]);
    end
  endtask

  int d, f, nd;

  initial begin
    w_mem[0] = 26'h0000001; w_mem[1] = 26'h3FFFFFF;
    w_mem[2] = 26'h2AAAAAA; w_mem[3] = 26'h1555555;
    x_mem[0] = 16'h0001;    x_mem[1] = 16'hFFFF;
    x_mem[2] = 16'h8001;    x_mem[3] = 16'h7FFE;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_scan_en", {en_f, en_n}, 2'b00);
    chk("rst_freeze",  {fz_f, fz_n}, 2'b00);
    chk("rst_busy",    {busy_f, busy_n}, 2'b00);
    chk("rst_valid_done", {vld_f, done_f, vld_n, done_n}, 4'b0000);
    chk("rst_fmt_err", {err_f, err_n}, 2'b00);
    chk("rst_words", {tap_f, w_f, x_f}, 44'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic readout, FREEZE=1
    sel = 1'b0;
    run(1'b1, 0, 1'b0, d, f, nd);
    chk("basic_en_at_start", en_at_s, 1'b0);
    chk("basic_fz_at_start", fz_at_s, 1'b1);
    chk("basic_done_cycle", d, 106);
    chk("basic_first_valid", f, 28);
    chk("basic_ndone", nd, 1);
    chk_words("basic");
    chk("basic_fmt_err", m_err, 1'b0);

    // No-freeze timing
    sel = 1'b1;
    run(1'b1, 0, 1'b0, d, f, nd);
    chk("nofz_en_at_start", en_at_s, 1'b1);
    chk("nofz_freeze_seen", fz_seen, 1'b0);
    chk("nofz_done_cycle", d, 105);
    chk("nofz_first_valid", f, 27);
    chk_words("nofz");

    // Format error on word 1 (tap 2), bit 20 of the x stream
    sel = 1'b0;
    inj = 1'b1;
    run(1'b1, 0, 1'b0, d, f, nd);
    inj = 1'b0;
    chk_words("fmt");
    chk("fmt_err_w0", q_err.size() > 0 ? q_err[0] : 1'bx, 1'b0);
    chk("fmt_err_w1", q_err.size() > 1 ? q_err[1] : 1'bx, 1'b1);
    chk("fmt_err_w3", q_err.size() > 3 ? q_err[3] : 1'bx, 1'b1);
    chk("fmt_err_after_done", m_err, 1'b1);
    run(1'b1, 0, 1'b0, d, f, nd);
    chk("fmt_err_cleared_on_start", err_at_s, 1'b0);
    chk("fmt_err_clean_run", m_err, 1'b0);

    // Start while busy is ignored, not queued
    run(1'b1, 50, 1'b0, d, f, nd);
    chk("busy_start_done_cycle", d, 106);
    chk("busy_start_ndone", nd, 1);
    chk_words("busy_start");
    clear_q();
    repeat (NB + 10) @(negedge clk);
    chk("busy_start_no_queue", q_tap.size(), 0);
    chk("busy_start_idle", m_busy, 1'b0);

    // Mid-scan reset at cycle 40
    @(negedge clk);
    r_start = 1'b1;
    @(posedge clk);
    #1 r_start = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_pre_active", {m_en, m_fz, m_busy}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_drop", {m_en, m_fz, m_busy}, 3'b000);
    clear_q();
    repeat (30) @(negedge clk);
    chk("rst_no_valid", q_tap.size(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(1'b1, 0, 1'b0, d, f, nd);
    chk("rst_recover_done", d, 106);
    chk_words("rst_recover");

    // Back-to-back readouts, second start in the done cycle
    run(1'b1, 0, 1'b1, d, f, nd);
    chk("b2b_first_done", d, 106);
    chk_words("b2b_first");
    chk("b2b_second_accepted", m_busy, 1'b1);
    run(1'b0, 0, 1'b0, d, f, nd);
    chk("b2b_second_ndone", nd, 1);
    chk_words("b2b_second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
